// File: rtl/pla_sweep_ctrl.sv
// pla_sweep_ctrl: sweeps a NIN-input function over a vector range and streams LSB-first packed results.
// Define PLA_SWEEP_SIG_EN to enable the 16-bit LFSR result signature on sig.
module pla_sweep_ctrl #(
  parameter int NIN = 10,
  parameter int WORD = 32,
  parameter int EVAL_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NIN-1:0]  base,
  input  logic [NIN:0]    count,
  output logic            busy,
  output logic            done,
  output logic [NIN-1:0]  func_x,
  input  logic            func_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_data,
  output logic            out_last,
  output logic [NIN:0]    onset_cnt,
  output logic [15:0]     sig
);
  localparam int FW = $clog2(WORD) + 1;
  localparam logic [NIN:0] FULL_SPACE = {1'b1, {NIN{1'b0}}};
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FLUSH, DONE} state_t;
  state_t state, state_nxt;
  logic [NIN-1:0] nx;
  logic [NIN:0] rem;
  logic [EVAL_LAT:0] vld;
  logic [EVAL_LAT+1:0] vsh;
  logic [WORD-1:0] pk;
  logic [FW-1:0] fill;
  logic go, issue, smp, acc, ofree, stall, drain_go, xfer;
  assign go = state == IDLE && start;
  assign smp = vld[EVAL_LAT];
  assign acc = out_valid && out_ready;
  assign ofree = !out_valid || out_ready;
  // Never let pack fill plus in-flight results exceed a word while the output is blocked
  assign stall = (int'(fill) + $countones(vld) >= WORD) && !ofree;
  assign issue = state == ISSUE && !stall;
  assign drain_go = state == DRAIN && vld == '0 && fill != '0 && ofree;
  assign xfer = (fill == FW'(WORD) && ofree) || drain_go;
  assign vsh = {vld, issue};
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  always_comb begin
    busy = state == ISSUE || state == DRAIN || state == FLUSH;
    done = state == DONE;
    state_nxt = go ? ISSUE :
                (issue && rem == (NIN+1)'(1)) ? DRAIN :
                drain_go ? FLUSH :
                (state == FLUSH && acc) ? DONE :
                state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nx <= '0;
      rem <= '0;
      func_x <= '0;
      vld <= '0;
      pk <= '0;
      fill <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      onset_cnt <= '0;
    end else begin
      vld <= vsh[EVAL_LAT:0];
      if (go) begin
        nx <= base;
        rem <= (count == '0) ? FULL_SPACE : count;
        onset_cnt <= '0;
      end
      if (issue) begin
        func_x <= nx;
        nx <= nx + 1'b1;
        rem <= rem - 1'b1;
      end
      if (xfer) begin
        pk <= {{(WORD-1){1'b0}}, smp & func_y};
        fill <= FW'(smp);
      end else if (smp) begin
        pk[fill[FW-2:0]] <= func_y;
        fill <= fill + 1'b1;
      end
      if (xfer) begin
        out_valid <= 1'b1;
        out_data <= pk;
        out_last <= drain_go;
      end else if (acc) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
      if (smp && func_y && onset_cnt != FULL_SPACE)
        onset_cnt <= onset_cnt + 1'b1;
    end
  end
`ifdef PLA_SWEEP_SIG_EN
  always_ff @(posedge clk)
    if (!rst_n) sig <= '0;
    else if (go) sig <= 16'hFFFF;
    else if (smp) sig <= {sig[14:0], 1'b0} ^ ((sig[15] ^ func_y) ? 16'h1021 : 16'h0000);
`else
  assign sig = 16'h0000;
`endif
endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// tb_pla_sweep_ctrl: directed sweeps checked against a truth-table model and a word scoreboard.
module tb_pla_sweep_ctrl;
  localparam int NIN = 10;
  localparam int WORD = 32;
  localparam int LAT = 1;
  localparam int LIMIT = 20000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [NIN-1:0] base = '0;
  logic [NIN:0] count = '0;
  logic busy, done, func_y, out_valid, out_last;
  logic out_ready = 1'b0;
  logic [NIN-1:0] func_x;
  logic [WORD-1:0] out_data;
  logic [NIN:0] onset_cnt;
  logic [15:0] sig;
  int n_chk = 0, n_fail = 0;
  int fsel = 0, rmode = 0, rctr = 0;
  int acc_cnt = 0, done_cnt = 0, issued = 0, exp_fx = 0, exp_on = 0, exp_n = 0;
  logic [WORD:0] exp_q[$];
  logic [15:0] exp_sig;
  time done_t, last_acc_t;
  logic [NIN:0] done_on;
  logic done_busy;
  logic [15:0] done_sig;
  pla_sweep_ctrl #(.NIN(NIN), .WORD(WORD), .EVAL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .func_x(func_x), .func_y(func_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .onset_cnt(onset_cnt), .sig(sig)
  );
  always #5 clk = ~clk;
  function automatic logic fn(input int sel, input logic [NIN-1:0] x);
    case (sel)
      0: return x[0];
      1: return 1'b1;
      2: return x[9];
      3: return x == 10'd5;
      default: return (^(x & 10'h2D5)) ^ (x[3] & x[7]);
    endcase
  endfunction
  // one-stage registered wrapper gives the function its single cycle of evaluation latency
  always_ff @(posedge clk) func_y <= fn(fsel, func_x);
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (rctr % 4 == 0) : (rctr % 64 == 0);
    rctr++;
  end
  initial begin : monitor
    logic pv, pr, pl;
    logic [WORD-1:0] pd;
    logic [NIN-1:0] prev_fx;
    logic [WORD:0] e;
    pv = 0; pr = 0; pl = 0; pd = '0; prev_fx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 0;
      else begin
        if (pv && !pr) begin
          chk("hold_data", out_data, pd);
          chk("hold_last", out_last, pl);
        end
        if (out_valid && out_ready) begin
          chk("word_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e[WORD-1:0]);
            chk("out_last", out_last, e[WORD]);
          end
          acc_cnt++;
          last_acc_t = $time;
        end
        if (busy && func_x != prev_fx) begin
          chk("func_x", func_x, exp_fx);
          exp_fx = (exp_fx + 1) % (1 << NIN);
          issued++;
        end
        if (done) begin
          done_cnt++;
          done_t = $time;
          done_on = onset_cnt;
          done_busy = busy;
          done_sig = sig;
        end
        pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      end
      prev_fx = func_x;
    end
  end
  task automatic plan(input int b, input int c, input int sel);
    logic [WORD-1:0] w;
    logic bt, fb;
    int nw;
    exp_n = c == 0 ? (1 << NIN) : c;
    nw = (exp_n + WORD - 1) / WORD;
    exp_on = 0;
    exp_sig = 16'hFFFF;
    exp_q.delete();
    for (int j = 0; j < nw; j++) begin
      w = '0;
      for (int k = 0; k < WORD; k++)
        if (j * WORD + k < exp_n) begin
          bt = fn(sel, NIN'((b + j * WORD + k) % (1 << NIN)));
          w[k] = bt;
          exp_on += int'(bt);
          fb = exp_sig[15] ^ bt;
          exp_sig = {exp_sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
      exp_q.push_back({j == nw - 1, w});
    end
`ifndef PLA_SWEEP_SIG_EN
    exp_sig = 16'h0000;
`endif
    fsel = sel;
  endtask
  task automatic run(input int b, input int c, input int mode, input bit restart, input bit abort);
    int dc0, k;
    time t0;
    rmode = mode;
    exp_fx = b;
    issued = 0;
    acc_cnt = 0;
    dc0 = done_cnt;
    @(posedge clk);
    #1 base = NIN'(b); count = (NIN+1)'(c); start = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    if (restart) begin
      repeat (40) @(posedge clk);
      #1 base = 10'd7; count = 11'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    if (abort) begin
      k = 0;
      while (acc_cnt < 4 && k < LIMIT) begin @(posedge clk); k++; end
      chk("abort_wait_timeout", acc_cnt >= 4, 1);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_func_x", func_x, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_onset", onset_cnt, 0);
      chk("rst_sig", sig, 0);
      exp_q.delete();
      repeat (20) @(posedge clk);
      chk("no_done_after_reset", done_cnt, dc0);
      return;
    end
    k = 0;
    while (done_cnt == dc0 && k < LIMIT) begin @(posedge clk); k++; end
    chk("done_timeout", done_cnt != dc0, 1);
    chk("onset_at_done", done_on, exp_on);
    chk("busy_at_done", done_busy, 0);
    chk("sig_at_done", done_sig, exp_sig);
    chk("vectors_issued", issued, exp_n);
    chk("words_left", exp_q.size(), 0);
    chk("done_gap", (done_t - last_acc_t) / 10, 1);
    if (mode == 0) chk("throughput", (done_t - t0 - 5) / 10 <= exp_n + LAT + 3, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    repeat (2) @(negedge clk);
    chk("onset_hold", onset_cnt, exp_on);
    chk("done_pulses", done_cnt - dc0, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_func_x", func_x, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_last", out_last, 0);
    chk("reset_onset", onset_cnt, 0);
    chk("reset_sig", sig, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    plan(1020, 10, 1);
    chk("model_wrap_word", exp_q[0], {1'b1, 32'h000003FF});
    chk("model_wrap_on", exp_on, 10);
    run(1020, 10, 0, 0, 0);
    plan(0, 0, 0);
    chk("model_x0_words", exp_q.size(), 32);
    chk("model_x0_w0", exp_q[0], {1'b0, 32'hAAAAAAAA});
    chk("model_x0_w31", exp_q[31], {1'b1, 32'hAAAAAAAA});
    chk("model_x0_on", exp_on, 512);
    run(0, 0, 0, 0, 0);
    plan(0, 1024, 2);
    chk("model_x9_w15", exp_q[15], {1'b0, 32'h0});
    chk("model_x9_w16", exp_q[16], {1'b0, 32'hFFFFFFFF});
    chk("model_x9_on", exp_on, 512);
    run(0, 1024, 1, 0, 0);
    plan(0, 64, 3);
    chk("model_eq5_w0", exp_q[0], {1'b0, 32'h00000020});
    chk("model_eq5_w1", exp_q[1], {1'b1, 32'h0});
    chk("model_eq5_on", exp_on, 1);
    run(0, 64, 0, 0, 0);
    plan(200, 1, 4);
    chk("model_single_words", exp_q.size(), 1);
    run(200, 1, 0, 0, 0);
    plan(300, 100, 4);
    run(300, 100, 1, 1, 0);
    plan(0, 0, 4);
    run(0, 0, 0, 0, 1);
    plan(517, 0, 4);
    run(517, 0, 2, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
